// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch stage and the Controller.
//   - opcode-group constants (opcode1[7:4])
//   - fetch_state_t : fetch sequencer states
//   - insn_len()    : instruction length (1 or 2 bytes) from the opcode group
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;

  // ALU instructions are marked by opcode1[7] set, i.e. group[3] set.
  localparam logic OP_ALU_MARK = 1'b1;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HALT_WAIT = 2'd2,
    HALTED    = 2'd3
  } fetch_state_t;

  function automatic logic [1:0] insn_len(input logic [3:0] group);
    logic [1:0] len;
    len = 2'd1;
    if (group[3] != OP_ALU_MARK) begin
      case (group)
        OP_LDI, OP_LD, OP_ST, OP_JMP: len = 2'd2;
        default:                      len = 2'd1;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/fetch_len_dec.sv
// fetch_len_dec: combinational opcode-group to instruction-length decoder.
// Ports:
//   op_group  in  4  opcode1[7:4]
//   len       out 2  instruction length in bytes (1 or 2)
module fetch_len_dec
  import cpu_pkg::*;
(
  input  logic [3:0] op_group,
  output logic [1:0] len
);

  always_comb begin
    len = insn_len(op_group);
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the pc, reads one/two-byte
// instructions from a combinational ROM into a registered instruction
// register and hands them to the Controller with a valid/ready handshake.
// Taken jumps flush the fall-through fetch, costing one bubble.
// Ports:
//   clk, reset            clock, async active-high reset
//   rom_address           out 8   current pc
//   rom_data1/rom_data2   in  8   ROM bytes at pc and pc+1
//   ir_op1/ir_op2/ir_pc   out 8   instruction register
//   ir_valid / ir_ready   handshake (accept = ir_valid & ir_ready)
//   jump_taken/jump_target  jump request for the instruction being accepted
//   halted                out 1   HALT has been accepted
//   instr_count           out COUNT_W  accepted-instruction counter (wraps)
//
// state     | meaning
// ----------+-------------------------------------------------------
// BOOT      | one cycle after reset, lets the ROM output settle
// RUN       | fetching, one instruction per cycle when not stalled
// HALT_WAIT | HALT sits in the IR, waiting to be accepted; no fetch
// HALTED    | stopped, outputs frozen until reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'h7F,
  parameter int         COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [7:0]         rom_address,
  input  logic [7:0]         rom_data1,
  input  logic [7:0]         rom_data2,
  output logic [7:0]         ir_op1,
  output logic [7:0]         ir_op2,
  output logic [7:0]         ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               jump_taken,
  input  logic [7:0]         jump_target,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  fetch_state_t state;
  logic [7:0]   pc;
  logic [1:0]   len;
  logic         accept;
  logic         take_jump;
  logic         load_en;

  fetch_len_dec u_len_dec (
    .op_group (rom_data1[7:4]),
    .len      (len)
  );

  assign rom_address = pc;
  assign accept      = ir_valid & ir_ready;
  // Only a jump accepted while running redirects the pc; in HALT_WAIT
  // the accepted instruction is the HALT itself and the jump is ignored.
  assign take_jump   = (state == RUN) & accept & jump_taken;
  assign load_en     = (state == RUN) & (~ir_valid | ir_ready) & ~take_jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ir_op1      <= 8'h00;
      ir_op2      <= 8'h00;
      ir_pc       <= 8'h00;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      if (accept)
        instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};

      case (state)
        BOOT: state <= RUN;

        RUN: begin
          if (take_jump) begin
            pc       <= jump_target;
            ir_valid <= 1'b0;
          end else if (load_en) begin
            ir_op1   <= rom_data1;
            ir_op2   <= (len == 2'd2) ? rom_data2 : 8'h00;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (rom_data1 == HALT_OPCODE)
              state <= HALT_WAIT;
            else
              pc <= pc + {6'b0, len};
          end
        end

        HALT_WAIT: begin
          if (accept) begin
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= HALTED;
          end
        end

        HALTED: ;

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_address;
  logic [7:0]  rom_data1;
  logic [7:0]  rom_data2;
  logic [7:0]  ir_op1;
  logic [7:0]  ir_op2;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_taken;
  logic [7:0]  jump_target;
  logic        halted;
  logic [15:0] instr_count;

  logic [7:0]  rom [256];

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(8'h00), .HALT_OPCODE(8'h7F), .COUNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .rom_data1   (rom_data1),
    .rom_data2   (rom_data2),
    .ir_op1      (ir_op1),
    .ir_op2      (ir_op2),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data1 = rom[rom_address];
  assign rom_data2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [7:0] op1, input logic [7:0] op2,
                        input logic [7:0] pc);
    chk({tag, ".valid"}, ir_valid, 1);
    chk({tag, ".op1"}, ir_op1, op1);
    chk({tag, ".op2"}, ir_op2, op2);
    chk({tag, ".pc"}, ir_pc, pc);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ir_ready    = 1'b1;
    jump_taken  = 1'b0;
    jump_target = 8'h00;
    clear_rom();

    // ---- basic delivery, backpressure, jump ----
    rom[0] = 8'h00; rom[1] = 8'h2F; rom[2] = 8'h01; rom[3] = 8'h85;
    rom[4] = 8'h40; rom[5] = 8'h10; rom[6] = 8'h85;
    rom[16] = 8'h11; rom[17] = 8'hAA;
    tick();
    #1;
    chk("rst.valid", ir_valid, 0);
    chk("rst.addr", rom_address, 8'h00);
    chk("rst.halted", halted, 0);
    chk("rst.count", instr_count, 0);
    chk("rst.op1", ir_op1, 0);
    reset = 1'b0;

    tick();
    chk("boot.valid", ir_valid, 0);
    tick();
    chk_ir("i0", 8'h00, 8'h00, 8'h00);
    chk("i0.addr", rom_address, 8'h01);
    tick();
    chk_ir("i1", 8'h2F, 8'h01, 8'h01);
    chk("i1.addr", rom_address, 8'h03);
    chk("i1.count", instr_count, 1);

    // Backpressure; a jump request without accept must be ignored.
    ir_ready    = 1'b0;
    jump_taken  = 1'b1;
    jump_target = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ir("bp", 8'h2F, 8'h01, 8'h01);
      chk("bp.addr", rom_address, 8'h03);
      chk("bp.count", instr_count, 1);
    end
    jump_taken = 1'b0;
    ir_ready   = 1'b1;
    tick();
    chk_ir("i3", 8'h85, 8'h00, 8'h03);
    chk("i3.count", instr_count, 2);
    tick();
    chk_ir("i4", 8'h40, 8'h10, 8'h04);
    chk("i4.count", instr_count, 3);
    chk("i4.addr", rom_address, 8'h06);

    jump_taken  = 1'b1;
    jump_target = 8'h10;
    tick();
    jump_taken = 1'b0;
    chk("jmp.bubble", ir_valid, 0);
    chk("jmp.addr", rom_address, 8'h10);
    chk("jmp.count", instr_count, 4);
    tick();
    chk_ir("tgt", 8'h11, 8'hAA, 8'h10);
    chk("tgt.addr", rom_address, 8'h12);

    // ---- pc wrap at 255 ----
    clear_rom();
    rom[255] = 8'h12;
    do_reset();
    begin
      int n;
      n = 0;
      while (!(ir_valid && ir_pc == 8'hFF) && n < 300) begin
        tick();
        n++;
      end
      chk("wrap.timeout", (n < 300), 1);
    end
    chk_ir("wrap", 8'h12, 8'h00, 8'hFF);
    chk("wrap.addr", rom_address, 8'h01);
    chk("wrap.count", instr_count, 255);
    tick();
    chk_ir("wrap.next", 8'h00, 8'h00, 8'h01);

    // ---- halt ----
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h7F; rom[2] = 8'h85;
    do_reset();
    tick();
    tick();
    chk_ir("h0", 8'h85, 8'h00, 8'h00);
    tick();
    chk_ir("h1", 8'h7F, 8'h00, 8'h01);
    chk("h1.addr", rom_address, 8'h01);
    jump_taken  = 1'b1;
    jump_target = 8'h20;
    tick();
    jump_taken = 1'b0;
    chk("halt.halted", halted, 1);
    chk("halt.valid", ir_valid, 0);
    chk("halt.addr", rom_address, 8'h01);
    chk("halt.count", instr_count, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted.valid", ir_valid, 0);
      chk("halted.addr", rom_address, 8'h01);
      chk("halted.op1", ir_op1, 8'h7F);
      chk("halted.count", instr_count, 2);
    end

    // ---- asynchronous reset mid-operation ----
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h90;
    do_reset();
    ir_ready = 1'b0;
    tick();
    tick();
    chk_ir("ar.pre", 8'h85, 8'h00, 8'h00);
    tick();
    chk("ar.pre.addr", rom_address, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.valid", ir_valid, 0);
    chk("ar.addr", rom_address, 8'h00);
    chk("ar.op1", ir_op1, 0);
    chk("ar.count", instr_count, 0);
    chk("ar.halted", halted, 0);
    tick();
    reset    = 1'b0;
    ir_ready = 1'b1;
    tick();
    chk("ar.boot", ir_valid, 0);
    tick();
    chk_ir("ar.restart", 8'h85, 8'h00, 8'h00);
    tick();
    chk_ir("ar.next", 8'h90, 8'h00, 8'h01);
    chk("ar.next.count", instr_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the Controller/datapath.
- Owns the program counter and drives rom_address.
- Captures the one- or two-byte instruction from the ROM's combinational outputs (rom_data1, rom_data2) into a registered instruction register.
- Presents the instruction to the Controller with a valid/ready handshake and applies taken jumps with a one-cycle flush.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OPCODE, 8'h7F, opcode1 value that stops fetching.
- COUNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- rom_address  out  8  equals pc (combinational from the pc register).
- rom_data1  in  8  ROM byte at rom_address.
- rom_data2  in  8  ROM byte at rom_address+1 (0 when rom_address==255).
- ir_op1  out  8  registered opcode1 to the Controller.
- ir_op2  out  8  registered opcode2/operand; 0 for one-byte instructions.
- ir_pc  out  8  address of the instruction held in ir_op1.
- ir_valid  out  1  instruction register holds a live instruction.
- ir_ready  in  1  downstream accepts the instruction this cycle.
- jump_taken  in  1  Controller jumpCond for the instruction being accepted.
- jump_target  in  8  jump destination (the accepted jump's operand).
- halted  out  1  high once the HALT instruction has been accepted.
- instr_count  out  COUNT_W  number of accepted instructions, wraps.

Behaviour:
- Reset is asynchronous and active-high; while asserted, all state is held in its reset value. Reset values:
  - pc=RESET_PC
  - ir_op1=0, ir_op2=0, ir_pc=0, ir_valid=0
  - halted=0, instr_count=0
  - state=BOOT
- Instruction length is decoded from rom_data1[7:4]:
  - 0001 (LDI), 0010 (LD), 0011 (ST), 0100 (JMP): 2 bytes.
  - Everything else, including 0000 NOP, 1xxx ALU, 0101-0111 and HALT: 1 byte.
- pc arithmetic is 8-bit modulo 256. Example: a two-byte instruction at 255 gives next pc=1, with ir_op2 taken as 0 from the ROM.
- accept = ir_valid & ir_ready.
- load = (state==RUN) & (~ir_valid | ir_ready) & ~(accept & jump_taken).
- States:
  - BOOT: one cycle with ir_valid=0, then go to RUN. Absorbs the ROM settle after reset.
  - RUN, on load:
    - ir_op1<=rom_data1.
    - ir_op2<=(len==2)?rom_data2:0.
    - ir_pc<=pc, ir_valid<=1, pc<=pc+len.
    - If rom_data1==HALT_OPCODE, go to HALT_WAIT and leave pc unchanged.
  - RUN, accept & jump_taken:
    - pc<=jump_target, ir_valid<=0.
    - Nothing is loaded this cycle, so the fall-through fetch is discarded.
    - The target instruction is valid two cycles after the accepting edge (one bubble).
  - RUN, accept without load (impossible by definition) or ir_valid & ~ir_ready: hold all registers; this is backpressure.
  - HALT_WAIT: no fetch. On accept:
    - ir_valid<=0, halted<=1, go to HALTED.
    - jump_taken is ignored here.
  - HALTED: all outputs frozen, ir_valid=0. Exit only via reset.
- jump_taken is sampled only when accept=1; at all other times it is ignored.
- instr_count increments by 1 on every accept, including jumps and HALT, and wraps at 2^COUNT_W.
- Throughput: one instruction per cycle when ir_ready is held high and there are no jumps.
- Reset mid-operation: an asynchronous return to the reset values, discarding any pending instruction. Fetching resumes from RESET_PC after BOOT.
- Simultaneous accept and jump_taken on a HALT instruction: HALT handling wins; the jump is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode-group constants OP_NOP=4'b0000, OP_LDI=4'b0001, OP_LD=4'b0010, OP_ST=4'b0011, OP_JMP=4'b0100.
  - ALU group marker (bit7=1).
  - fetch_state_t enum {BOOT, RUN, HALT_WAIT, HALTED}.
  - Function insn_len(opcode1) returning 1 or 2.
- One sub-module is natural: fetch_len_dec, a combinational opcode-to-length decoder also reusable by the Controller. Everything else stays in fetch_unit.

Test Plan:
- Reset, ROM {0:00, 1:2F, 2:01, 3:85}, ir_ready=1. Expected:
  - ir_valid stays 0 for BOOT.
  - Then deliver (00,00,pc0), (2F,01,pc1), (85,00,pc3).
  - instr_count=3.
- Backpressure: hold ir_ready=0 for 4 cycles with 2F/01 valid. Expected:
  - ir_op1/ir_op2/ir_pc stable and rom_address stays 3.
  - After release, the next instruction appears on the following cycle.
- Jump: ROM {4:40, 5:10, 6:85, 16:11, 17:AA}; accept (40,10) with jump_taken=1 and jump_target=10. Expected:
  - One bubble with ir_valid=0.
  - Then (11,AA,pc16); 85 at pc6 is never delivered.
- Wrap: rom[255]=12 (two-byte), rom[0]=00 after reset. Expected:
  - Deliver (12,00,pc255).
  - Next fetch is at pc=1.
- Halt: ROM {0:85, 1:7F, 2:85}. Expected:
  - Deliver 85, then 7F.
  - After 7F is accepted: halted=1, ir_valid=0, and pc 2 is never fetched.
  - jump_taken=1 on 7F's accept has no effect.
- Reset mid-operation: assert reset asynchronously while ir_valid=1 with ir_ready=0. Expected:
  - Outputs go to reset values immediately, before the next clk edge.
  - Fetch restarts at RESET_PC.
